// File: rtl/jstk_spi_responder.sv
// SPI mode-0 responder emulating a PmodJSTK: answers a 5-byte X/Y/button frame and captures the LED command byte.
// Latency: miso updates SYNC_STAGES+1 clk after a raw sclk fall; frame_done/frame_err pulse SYNC_STAGES+1..+2 clk after ss rises.
// Backpressure: none; the SPI master paces every transfer and the responder only follows its sclk/ss.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ss, sclk, mosi      raw SPI inputs from the master (asynchronous to clk)
//   miso                registered SPI output to the master
//   x_pos, y_pos        10-bit positions, sampled when ss falls
//   buttons             3 button bits, sampled when ss falls
//   leds                LED bits from the last completed frame with cmd bit7 set
//   frame_done          1-cycle pulse when ss rises after a complete frame
//   frame_err           1-cycle pulse when ss rises before the frame completed
module jstk_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BYTES   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic [1:0] leds,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int FRAME_BITS = NUM_BYTES * 8;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, ABORT} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync, ss_sync, mosi_sync;
  logic                    sclk_q, ss_q;
  logic [FRAME_BITS-2:0]   shreg;      // bits still to send after the one on miso
  logic [CNT_W-1:0]        bit_cnt;
  logic [6:0]              rx_byte;    // last 7 mosi bits; the 8th completes the command
  logic                    cmd_en;
  logic [1:0]              cmd_led;
  logic [FRAME_BITS-1:0]   frame_init;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  // Synchronizers reset to 0 so that a reset while ss is held low never
  // produces a false ss falling edge: the responder waits for ss to go high
  // and fall again before starting a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign ss_rise   = ss_s & ~ss_q;
  assign ss_fall   = ~ss_s & ss_q;

  // Transmit image: the five report bytes at the top, any extra bytes zero.
  always_comb begin
    frame_init = '0;
    frame_init[FRAME_BITS-1 -: 40] = {x_pos[7:0], 6'b0, x_pos[9:8],
                                      y_pos[7:0], 6'b0, y_pos[9:8],
                                      5'b0, buttons};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sclk_q     <= 1'b0;
      ss_q       <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      rx_byte    <= '0;
      cmd_en     <= 1'b0;
      cmd_led    <= 2'b00;
      miso       <= 1'b0;
      leds       <= 2'b00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sclk_q     <= sclk_s;
      ss_q       <= ss_s;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (ss_fall) begin
            miso    <= frame_init[FRAME_BITS-1];
            shreg   <= frame_init[FRAME_BITS-2:0];
            bit_cnt <= '0;
            rx_byte <= '0;
            cmd_en  <= 1'b0;
            cmd_led <= 2'b00;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state <= ABORT;
          end else begin
            if (sclk_rise) begin
              rx_byte <= {rx_byte[5:0], mosi_s};
              bit_cnt <= bit_cnt + CNT_W'(1);
              // 8th rising edge: {rx_byte, mosi_s} is the command byte.
              if (bit_cnt == CNT_W'(7)) begin
                cmd_en  <= rx_byte[6];
                cmd_led <= {rx_byte[0], mosi_s};
              end
              if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                state <= DONE;
              end
            end
            if (sclk_fall) begin
              miso  <= shreg[FRAME_BITS-2];
              shreg <= {shreg[FRAME_BITS-3:0], 1'b0};
            end
          end
        end
        DONE: begin
          // Overclocking past the frame only clocks out zeros.
          if (sclk_fall) begin
            miso  <= 1'b0;
            shreg <= {shreg[FRAME_BITS-3:0], 1'b0};
          end
          if (ss_rise) begin
            frame_done <= 1'b1;
            miso       <= 1'b0;
            if (cmd_en) begin
              leds <= cmd_led;
            end
            state <= IDLE;
          end
        end
        ABORT: begin
          frame_err <= 1'b1;
          miso      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jstk_spi_responder.sv
module tb_jstk_spi_responder;

  logic       clk = 1'b0;
  logic       rst, ss, sclk, mosi, miso;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic [1:0] leds;
  logic       frame_done, frame_err;

  int tests = 0;
  int fails = 0;
  int done_cyc = 0;
  int err_cyc  = 0;
  int both_cyc = 0;
  logic [1:0] led_model;

  localparam int NO_EVENT = 1000;

  always #5 clk = ~clk;

  jstk_spi_responder #(.SYNC_STAGES(2), .NUM_BYTES(5)) dut (
    .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons), .leds(leds),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  // Count pulse cycles: a proper pulse contributes exactly one.
  always @(negedge clk) begin
    if (frame_done) done_cyc <= done_cyc + 1;
    if (frame_err)  err_cyc  <= err_cyc + 1;
    if (frame_done && frame_err) both_cyc <= both_cyc + 1;
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the byte list the master should read, bit i of the stream
  // being bit (7 - i%8) of byte i/8; bits past the report, or after a reset
  // cut the frame, read as zero. Result is right-aligned in n bits.
  function automatic logic [47:0] model_rd(input logic [9:0] x, input logic [9:0] y,
                                           input logic [2:0] b, input int n, input int cut);
    logic [7:0]  by [5];
    logic [47:0] r;
    logic        bv;
    by[0] = x[7:0];
    by[1] = {6'b0, x[9:8]};
    by[2] = y[7:0];
    by[3] = {6'b0, y[9:8]};
    by[4] = {5'b0, b};
    r = '0;
    for (int i = 0; i < n; i++) begin
      bv = (i < 40 && i < cut) ? by[i / 8][7 - (i % 8)] : 1'b0;
      r  = {r[46:0], bv};
    end
    return r;
  endfunction

  // SPI mode-0 master: mosi changes while sclk low, miso sampled at the rise.
  task automatic spi_frame(input int nbits, input logic [7:0] cmd, input int half,
                           input int chg_bit, input logic [9:0] chg_x, input int rst_bit,
                           output logic [47:0] rd);
    rd = '0;
    ss = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) x_pos = chg_x;
      if (i == rst_bit) begin
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
      mosi = (i < 8) ? cmd[7 - i] : 1'($urandom);
      repeat (half) @(negedge clk);
      rd   = {rd[46:0], miso};
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (half) @(negedge clk);
    ss   = 1'b1;
    mosi = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic run_check(input string tag, input logic [9:0] x, input logic [9:0] y,
                           input logic [2:0] b, input logic [7:0] cmd, input int nbits,
                           input int half, input int chg_bit, input logic [9:0] chg_x,
                           input int rst_bit, input logic [47:0] exp_rd,
                           input logic [1:0] exp_leds, input int exp_done, input int exp_err);
    logic [47:0] rd;
    int d0, e0;
    x_pos   = x;
    y_pos   = y;
    buttons = b;
    d0 = done_cyc;
    e0 = err_cyc;
    spi_frame(nbits, cmd, half, chg_bit, chg_x, rst_bit, rd);
    check({tag, " miso_bits"}, rd, exp_rd);
    check({tag, " done_pulses"}, 48'(done_cyc - d0), 48'(exp_done));
    check({tag, " err_pulses"}, 48'(err_cyc - e0), 48'(exp_err));
    check({tag, " leds"}, 48'(leds), 48'(exp_leds));
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  b;
    logic [7:0]  cmd;
    int          nbits;
    int          half;
    logic [47:0] exp_rd;
    logic [1:0]  exp_leds;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [9:0] rx, ry;
    logic [2:0] rb;
    logic [7:0] rc;
    int         rn, rh;

    tbl[0] = '{10'h2A5, 10'h1C3, 3'b101, 8'h83, 40, 4, 48'h00A502C30105, 2'b11, 1, 0};
    tbl[1] = '{10'h2A5, 10'h1C3, 3'b101, 8'h03, 40, 5, 48'h00A502C30105, 2'b11, 1, 0};
    tbl[2] = '{10'h2A5, 10'h1C3, 3'b101, 8'h81, 17, 6, 48'h000000014A05, 2'b11, 0, 1};
    tbl[3] = '{10'h2A5, 10'h1C3, 3'b101, 8'h82, 48, 4, 48'hA502C3010500, 2'b10, 1, 0};
    tbl[4] = '{10'h3FF, 10'h000, 3'b111, 8'hFE, 40, 5, 48'h00FF03000007, 2'b10, 1, 0};
    tbl[5] = '{10'h155, 10'h2AA, 3'b000, 8'h80, 40, 7, 48'h005501AA0200, 2'b00, 1, 0};

    rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    x_pos = '0; y_pos = '0; buttons = '0;
    repeat (4) @(negedge clk);
    check("reset miso", 48'(miso), 48'd0);
    check("reset leds", 48'(leds), 48'd0);
    check("reset frame_done", 48'(frame_done), 48'd0);
    check("reset frame_err", 48'(frame_err), 48'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_check($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].cmd,
                tbl[i].nbits, tbl[i].half, NO_EVENT, 10'h0, NO_EVENT,
                tbl[i].exp_rd, tbl[i].exp_leds, tbl[i].exp_done, tbl[i].exp_err);
    end
    led_model = 2'b00;

    // x changes after bit 4: this frame keeps the snapshot, next one sees it.
    run_check("xchg_cur", 10'h000, 10'h123, 3'b010, 8'h00, 40, 5, 5, 10'h3FF, NO_EVENT,
              model_rd(10'h000, 10'h123, 3'b010, 40, NO_EVENT), led_model, 1, 0);
    run_check("xchg_next", 10'h3FF, 10'h123, 3'b010, 8'h00, 40, 5, NO_EVENT, 10'h0, NO_EVENT,
              model_rd(10'h3FF, 10'h123, 3'b010, 40, NO_EVENT), led_model, 1, 0);
    check("xchg_next b0b1", model_rd(10'h3FF, 10'h123, 3'b010, 40, NO_EVENT) >> 24, 48'hFF03);

    // Reset at bit 20 after leds were set: frame lost, leds cleared, no pulses.
    run_check("pre_rst", 10'h1AB, 10'h0F0, 3'b001, 8'h83, 40, 4, NO_EVENT, 10'h0, NO_EVENT,
              model_rd(10'h1AB, 10'h0F0, 3'b001, 40, NO_EVENT), 2'b11, 1, 0);
    run_check("mid_rst", 10'h1AB, 10'h0F0, 3'b001, 8'h83, 40, 4, NO_EVENT, 10'h0, 20,
              model_rd(10'h1AB, 10'h0F0, 3'b001, 40, 20), 2'b00, 0, 0);
    run_check("post_rst", 10'h1AB, 10'h0F0, 3'b001, 8'h81, 40, 4, NO_EVENT, 10'h0, NO_EVENT,
              model_rd(10'h1AB, 10'h0F0, 3'b001, 40, NO_EVENT), 2'b01, 1, 0);
    led_model = 2'b01;

    for (int k = 0; k < 20; k++) begin
      rx = 10'($urandom);
      ry = 10'($urandom);
      rb = 3'($urandom);
      rc = 8'($urandom);
      rh = $urandom_range(4, 7);
      case ($urandom_range(0, 2))
        0:       rn = 40;
        1:       rn = $urandom_range(41, 48);
        default: rn = $urandom_range(1, 39);
      endcase
      if (rn >= 40 && rc[7]) led_model = rc[1:0];
      run_check($sformatf("rand%0d", k), rx, ry, rb, rc, rn, rh, NO_EVENT, 10'h0, NO_EVENT,
                model_rd(rx, ry, rb, rn, NO_EVENT), led_model,
                (rn >= 40) ? 1 : 0, (rn >= 40) ? 0 : 1);
    end

    check("done_and_err_overlap", 48'(both_cyc), 48'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
